cnl_job_dispatcher: RTL and testbench

Host-side job controller driving one `cnn_layer_accel_quad` job/pixel interface in the `clk_if` domain. It accepts a job descriptor from an upstream scheduler, issues `job_start`/`job_parameters` and waits for `job_accept`. It answers the quad's fetch request and gates an exact number of pixel beats from an upstream source into the quad, then acknowledges `job_complete` and reports done status. It is the synthesizable counterpart of the job-issuing side of the verification environment.

---
 rtl/cnl_job_dispatcher_if.sv | 42 ++++
 rtl/cnl_job_dispatcher.sv | 118 +++++++++++
 tb/tb_cnl_job_dispatcher.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnl_job_dispatcher_if.sv
// Descriptor, job-issue, fetch, completion and pixel-stream signals of one dispatcher/quad pairing.
// The master modport is the dispatcher's view; the slave modport is the scheduler/quad/source side.
interface cnl_job_dispatcher_if #(
   parameter int C_PARAM_WIDTH    = 128,
   parameter int C_BEAT_CNT_WIDTH = 20
);
   logic                        desc_valid;
   logic                        desc_ready;
   logic [C_PARAM_WIDTH-1:0]    desc_params;
   logic [C_BEAT_CNT_WIDTH-1:0] desc_num_pixel_beats;
   logic                        job_start;
   logic                        job_accept;
   logic [C_PARAM_WIDTH-1:0]    job_parameters;
   logic                        job_fetch_request;
   logic                        job_fetch_ack;
   logic                        job_fetch_complete;
   logic                        job_complete;
   logic                        job_complete_ack;
   logic                        src_pixel_valid;
   logic                        src_pixel_ready;
   logic [127:0]                src_pixel_data;
   logic                        pixel_valid;
   logic                        pixel_ready;
   logic [127:0]                pixel_data;
   logic                        busy;
   logic                        done_valid;
   logic                        done_error;

   modport master (
      input  desc_valid, desc_params, desc_num_pixel_beats, job_accept, job_fetch_request,
             job_complete, src_pixel_valid, src_pixel_data, pixel_ready,
      output desc_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
             job_complete_ack, src_pixel_ready, pixel_valid, pixel_data, busy, done_valid, done_error
   );

   modport slave (
      output desc_valid, desc_params, desc_num_pixel_beats, job_accept, job_fetch_request,
             job_complete, src_pixel_valid, src_pixel_data, pixel_ready,
      input  desc_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
             job_complete_ack, src_pixel_ready, pixel_valid, pixel_data, busy, done_valid, done_error
   );
endinterface

// File: rtl/cnl_job_dispatcher.sv
// Issues one job to a CNN layer quad, gates exactly the descriptor's pixel-beat count, then acks completion.
// Optional watchdog abort on stalled handshakes is built only when CNL_DISPATCH_TIMEOUT_EN is defined.
module cnl_job_dispatcher #(
   parameter int C_PARAM_WIDTH    = 128,
   parameter int C_BEAT_CNT_WIDTH = 20,
   parameter int C_TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk_if,
   input  logic                  rst,
   cnl_job_dispatcher_if.master  ctl
);
   typedef enum logic [2:0] {
      IDLE, START, WAIT_FETCH, FETCH, FETCH_DONE, WAIT_DONE, ACK_DONE
   } state_t;

   state_t                      state, state_nxt;
   logic [C_BEAT_CNT_WIDTH-1:0] remaining;
   logic [C_PARAM_WIDTH-1:0]    params_q;
   logic                        complete_sticky;
   logic                        gate, beat, timeout;
   logic                        desc_ready_q, job_start_q, fetch_ack_q, fetch_complete_q;
   logic                        complete_ack_q, busy_q, done_valid_q;

   assign gate = (state == FETCH) && (remaining != '0);
   assign beat = ctl.src_pixel_valid && ctl.pixel_ready && gate;

`ifdef CNL_DISPATCH_TIMEOUT_EN
   localparam int WD_W = $clog2(C_TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            in_wait;
   logic            done_error_q;

   assign in_wait = (state == START) || (state == WAIT_FETCH) || (state == WAIT_DONE);
   assign timeout = in_wait && (wd_cnt == WD_W'(C_TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_if) begin
      if (rst) begin
         wd_cnt       <= '0;
         done_error_q <= 1'b0;
      end else begin
         done_error_q <= timeout;
         if (!in_wait || state_nxt != state) wd_cnt <= '0;
         else                                wd_cnt <= wd_cnt + 1'b1;
      end
   end
   assign ctl.done_error = done_error_q;
`else
   assign timeout        = 1'b0;
   assign ctl.done_error = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (ctl.desc_valid && desc_ready_q) state_nxt = START;
         START:      if (ctl.job_accept) state_nxt = WAIT_FETCH;
         WAIT_FETCH: if (ctl.job_fetch_request) state_nxt = FETCH;
         // Leave on the edge that takes the last beat so fetch_complete lands one cycle later.
         FETCH:      if (remaining == '0 || (remaining == C_BEAT_CNT_WIDTH'(1) && beat))
                        state_nxt = FETCH_DONE;
         FETCH_DONE: state_nxt = WAIT_DONE;
         WAIT_DONE:  if (ctl.job_complete || complete_sticky) state_nxt = ACK_DONE;
         ACK_DONE:   state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      if (timeout) state_nxt = IDLE;
   end

   always_ff @(posedge clk_if) begin
      if (rst) begin
         state            <= IDLE;
         remaining        <= '0;
         params_q         <= '0;
         complete_sticky  <= 1'b0;
         desc_ready_q     <= 1'b0;
         job_start_q      <= 1'b0;
         fetch_ack_q      <= 1'b0;
         fetch_complete_q <= 1'b0;
         complete_ack_q   <= 1'b0;
         busy_q           <= 1'b0;
         done_valid_q     <= 1'b0;
      end else begin
         state            <= state_nxt;
         desc_ready_q     <= (state_nxt == IDLE);
         job_start_q      <= (state_nxt == START);
         fetch_ack_q      <= (state == WAIT_FETCH) && (state_nxt == FETCH);
         fetch_complete_q <= (state_nxt == FETCH_DONE);
         complete_ack_q   <= (state_nxt == ACK_DONE);
         busy_q           <= (state_nxt != IDLE);
         done_valid_q     <= (state_nxt == ACK_DONE) || timeout;

         if (state == IDLE && state_nxt == START) begin
            params_q  <= ctl.desc_params;
            remaining <= ctl.desc_num_pixel_beats;
         end else if (beat) begin
            remaining <= remaining - 1'b1;
         end

         // Quad may finish before we have signalled fetch_complete; remember it until WAIT_DONE.
         if (state_nxt == IDLE)
            complete_sticky <= 1'b0;
         else if ((state == FETCH || state == FETCH_DONE) && ctl.job_complete)
            complete_sticky <= 1'b1;
      end
   end

   assign ctl.desc_ready         = desc_ready_q;
   assign ctl.job_start          = job_start_q;
   assign ctl.job_parameters     = params_q;
   assign ctl.job_fetch_ack      = fetch_ack_q;
   assign ctl.job_fetch_complete = fetch_complete_q;
   assign ctl.job_complete_ack   = complete_ack_q;
   assign ctl.busy               = busy_q;
   assign ctl.done_valid         = done_valid_q;
   assign ctl.pixel_valid        = ctl.src_pixel_valid && gate;
   assign ctl.src_pixel_ready    = ctl.pixel_ready && gate;
   assign ctl.pixel_data         = ctl.src_pixel_data;
endmodule

// File: tb/tb_cnl_job_dispatcher.sv
// Randomized job-level bench: a transaction model tracks beats owed per job and the expected pulse cycles.
module tb_cnl_job_dispatcher;
   logic clk_if = 1'b0;
   logic rst    = 1'b1;
   int   n_vec  = 0;
   int   n_err  = 0;

   always #5 clk_if = ~clk_if;

   cnl_job_dispatcher_if #(.C_PARAM_WIDTH(128), .C_BEAT_CNT_WIDTH(20)) b();

   cnl_job_dispatcher #(
      .C_PARAM_WIDTH(128), .C_BEAT_CNT_WIDTH(20), .C_TIMEOUT_CYCLES(100)
   ) dut (
      .clk_if(clk_if), .rst(rst), .ctl(b)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_if);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk_all_idle(input string tag);
      chk({tag, "_desc_ready"}, b.desc_ready, 0);
      chk({tag, "_job_start"},  b.job_start, 0);
      chk({tag, "_params"},     b.job_parameters, 0);
      chk({tag, "_fetch_ack"},  b.job_fetch_ack, 0);
      chk({tag, "_fetch_cmpl"}, b.job_fetch_complete, 0);
      chk({tag, "_cmpl_ack"},   b.job_complete_ack, 0);
      chk({tag, "_pix_valid"},  b.pixel_valid, 0);
      chk({tag, "_src_ready"},  b.src_pixel_ready, 0);
      chk({tag, "_busy"},       b.busy, 0);
      chk({tag, "_done"},       b.done_valid, 0);
      chk({tag, "_done_err"},   b.done_error, 0);
   endtask

   // One full job. pct = percent chance each cycle that source valid / sink ready is high.
   // cmpl_at >= 0 pulses job_complete once that many beats have moved; rst_at >= 0 resets then.
   task automatic run_job(input logic [127:0] prm, input int beats, input int acc_dly,
                          input int pct, input int cmpl_at, input int rst_at);
      int          xfers, last_k, wait_n;
      logic        got, early, fc_seen, xfer;
      logic [127:0] word;

      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         b.desc_valid           = 1;
         b.desc_params          = prm;
         b.desc_num_pixel_beats = 20'(beats);
         #1;
         got = b.desc_ready;
      end
      chk("desc_accepted", got, 1);
      if (!got) begin
         b.desc_valid = 0;
         return;
      end
      tick();
      b.desc_valid  = 0;
      b.desc_params = rnd128();
      #1;
      chk("job_start_rise", b.job_start, 1);
      chk("job_params", b.job_parameters, prm);
      chk("desc_ready_drop", b.desc_ready, 0);
      chk("busy_set", b.busy, 1);
      for (int i = 0; i < acc_dly; i++) begin
         tick();
         #1;
         chk("job_start_held", b.job_start, 1);
      end
      b.job_accept = 1;
      tick();
      b.job_accept = 0;
      #1;
      chk("job_start_fall", b.job_start, 0);

      // WAIT_FETCH: source offers data but the gate must stay shut.
      wait_n = $urandom_range(0, 3);
      b.src_pixel_valid = 1;
      b.pixel_ready     = 1;
      for (int i = 0; i <= wait_n; i++) begin
         if (i > 0) tick();
         b.job_fetch_request = (i == wait_n);
         #1;
         chk("gate_closed_wait", b.pixel_valid, 0);
         chk("no_ack_wait", b.job_fetch_ack, 0);
      end
      tick();
      b.job_fetch_request = 0;

      xfers   = 0;
      last_k  = (beats == 0) ? 0 : -10;
      early   = 0;
      fc_seen = 0;
      word    = rnd128();
      for (int k = 0; k < 20 * beats + 40; k++) begin
         if (k > 0) tick();
         if (rst_at >= 0 && xfers == rst_at) begin
            b.src_pixel_valid = 0;
            b.job_complete    = 0;
            rst = 1;
            tick();
            rst = 0;
            b.src_pixel_valid = 1;
            b.pixel_ready     = 1;
            #1;
            chk_all_idle("mid_reset");
            b.src_pixel_valid = 0;
            b.pixel_ready     = 0;
            return;
         end
         b.src_pixel_valid = ($urandom_range(99) < pct);
         b.pixel_ready     = ($urandom_range(99) < pct);
         b.src_pixel_data  = word;
         b.job_complete    = (cmpl_at >= 0 && xfers == cmpl_at && !early);
         if (b.job_complete) early = 1;
         #1;
         chk("fetch_ack", b.job_fetch_ack, k == 0);
         chk("gate_valid", b.pixel_valid, b.src_pixel_valid && xfers < beats);
         chk("gate_ready", b.src_pixel_ready, b.pixel_ready && xfers < beats);
         chk("fetch_complete", b.job_fetch_complete, k == last_k + 1);
         if (b.job_fetch_complete) begin
            fc_seen = 1;
            break;
         end
         xfer = b.src_pixel_valid && b.pixel_ready && (xfers < beats);
         if (xfer) begin
            chk("pixel_data", b.pixel_data, word);
            xfers++;
            if (xfers == beats) last_k = k;
            word = rnd128();
         end
      end
      chk("fetch_complete_seen", fc_seen, 1);
      chk("beats_total", xfers, beats);

      b.job_complete    = 0;
      b.src_pixel_valid = 1;
      b.pixel_ready     = 1;
      tick();
      #1;
      chk("fc_single_pulse", b.job_fetch_complete, 0);
      chk("gate_closed_after", b.pixel_valid, 0);
      chk("ack_not_early", b.job_complete_ack, 0);
      if (!early) begin
         wait_n = $urandom_range(0, 3);
         for (int i = 0; i < wait_n; i++) begin
            tick();
            #1;
            chk("ack_waiting", b.job_complete_ack, 0);
         end
         b.job_complete = 1;
         tick();
         b.job_complete = 0;
      end else begin
         tick();
      end
      #1;
      chk("complete_ack", b.job_complete_ack, 1);
      chk("done_valid", b.done_valid, 1);
      chk("done_error", b.done_error, 0);
      chk("busy_in_ack", b.busy, 1);
      tick();
      #1;
      chk("ack_single", b.job_complete_ack, 0);
      chk("done_single", b.done_valid, 0);
      chk("desc_ready_back", b.desc_ready, 1);
      chk("busy_clear", b.busy, 0);
      b.src_pixel_valid = 0;
      b.pixel_ready     = 0;
   endtask

   initial begin
      b.desc_valid = 0; b.desc_params = '0; b.desc_num_pixel_beats = '0;
      b.job_accept = 0; b.job_fetch_request = 0; b.job_complete = 0;
      b.src_pixel_valid = 0; b.src_pixel_data = '0; b.pixel_ready = 0;
      rst = 1;
      repeat (3) tick();
      b.src_pixel_valid = 1;
      b.pixel_ready     = 1;
      #1;
      chk_all_idle("reset");
      b.src_pixel_valid = 0;
      b.pixel_ready     = 0;
      rst = 0;

      run_job(128'h1234, 400, 3, 100, -1, -1);
      run_job(rnd128(), 0, 1, 100, -1, -1);
      run_job(rnd128(), 25, 2, 50, -1, -1);
      run_job(rnd128(), 20, 0, 100, 10, -1);
      run_job(rnd128(), 20, 1, 100, -1, 7);
      run_job(rnd128(), 13, 1, 60, -1, -1);
      for (int j = 0; j < 5; j++)
         run_job(rnd128(), $urandom_range(0, 40), $urandom_range(0, 4),
                 $urandom_range(30, 100), -1, -1);

`ifdef CNL_DISPATCH_TIMEOUT_EN
      begin
         int   tk;
         logic seen;
         seen = 0;
         tk   = -1;
         tick();
         b.desc_valid           = 1;
         b.desc_params          = 128'hBEEF;
         b.desc_num_pixel_beats = 20'd5;
         for (int i = 0; i < 20 && !b.desc_ready; i++) tick();
         tick();
         b.desc_valid = 0;
         b.job_accept = 1;
         tick();
         b.job_accept = 0;
         #1;
         for (int k = 0; k < 200 && !seen; k++) begin
            if (k > 0) tick();
            #1;
            if (b.done_valid) begin
               seen = 1;
               tk   = k;
            end
         end
         chk("timeout_cycles", tk, 100);
         chk("timeout_error", b.done_error, 1);
         chk("timeout_no_ack", b.job_complete_ack, 0);
         tick();
         #1;
         chk("timeout_busy_clear", b.busy, 0);
         chk("timeout_done_single", b.done_valid, 0);
      end
      run_job(rnd128(), 6, 1, 100, -1, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
